// File: rtl/s2p_pkg.sv
// s2p_pkg: FSM state encoding shared by the s_to_p deserializer files.
package s2p_pkg;
    localparam int S2P_STATE_W = 2;
    typedef enum logic [S2P_STATE_W-1:0] {S2P_IDLE, S2P_SHIFT, S2P_PARITY} s2p_state_e;
endpackage

// File: rtl/s2p_if.sv
// s2p_if: serial input side and valid/ready word output side of the deserializer.
interface s2p_if #(parameter int WIDTH = 4);
    logic             din;
    logic             din_valid;
    logic             sof;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             frame_err;
    logic             overflow;
    logic             parity_err;
    modport master (
        output din, din_valid, sof, dout_ready,
        input  dout, dout_valid, frame_err, overflow, parity_err
    );
    modport slave (
        input  din, din_valid, sof, dout_ready,
        output dout, dout_valid, frame_err, overflow, parity_err
    );
endinterface

// File: rtl/s2p_out_buf.sv
// s2p_out_buf: one-entry valid/ready word buffer with overflow pulse and parity flag.
module s2p_out_buf #(parameter int WIDTH = 4) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             perr_in,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overflow,
    output logic             parity_err
);
    logic [WIDTH-1:0] data_q, data_d;
    logic valid_q, valid_d, ovf_q, ovf_d, perr_q, perr_d;
    always_comb begin
        data_d = data_q;
        perr_d = perr_q;
        ovf_d = 1'b0;
        valid_d = valid_q & ~ready;
        // valid_d here means "still full after this edge's handshake"
        if (load) begin
            if (valid_d) ovf_d = 1'b1;
            else begin
                data_d = word;
                perr_d = perr_in;
                valid_d = 1'b1;
            end
        end
        if (!valid_d) perr_d = 1'b0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            valid_q <= 1'b0;
            ovf_q <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            data_q <= data_d;
            valid_q <= valid_d;
            ovf_q <= ovf_d;
            perr_q <= perr_d;
        end
    end
    assign dout = data_q;
    assign dout_valid = valid_q;
    assign overflow = ovf_q;
    assign parity_err = perr_q;
endmodule

// File: rtl/s_to_p.sv
// s_to_p: framed serial-to-parallel deserializer; S2P_PARITY_EN adds an even-parity bit per frame.
module s_to_p import s2p_pkg::*; #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1
) (
    input logic   clk,
    input logic   rst,
    s2p_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    s2p_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic ferr_q, ferr_d, load, perr_in;
`ifdef S2P_PARITY_EN
    logic par_bit;
`endif
    // shifting toward the far end leaves bit 0 of the frame in its final position after WIDTH bits
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w, input logic b);
        return LSB_FIRST ? {b, w[WIDTH-1:1]} : {w[WIDTH-2:0], b};
    endfunction
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        sh_d = sh_q;
        ferr_d = 1'b0;
        load = 1'b0;
`ifdef S2P_PARITY_EN
        par_bit = 1'b0;
`endif
        if (bus.din_valid && bus.sof) begin
            ferr_d = state_q != S2P_IDLE;
            sh_d = shift_in('0, bus.din);
            cnt_d = CW'(1);
            state_d = S2P_SHIFT;
        end else if (bus.din_valid && state_q == S2P_SHIFT) begin
            sh_d = shift_in(sh_q, bus.din);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                cnt_d = '0;
`ifdef S2P_PARITY_EN
                state_d = S2P_PARITY;
`else
                state_d = S2P_IDLE;
                load = 1'b1;
`endif
            end
        end
`ifdef S2P_PARITY_EN
        else if (bus.din_valid && state_q == S2P_PARITY) begin
            state_d = S2P_IDLE;
            load = 1'b1;
            par_bit = bus.din;
        end
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S2P_IDLE;
            cnt_q <= '0;
            sh_q <= '0;
            ferr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            sh_q <= sh_d;
            ferr_q <= ferr_d;
        end
    end
`ifdef S2P_PARITY_EN
    assign perr_in = ^sh_d ^ par_bit;
`else
    assign perr_in = 1'b0;
`endif
    assign bus.frame_err = ferr_q;
    s2p_out_buf #(.WIDTH(WIDTH)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .word       (sh_d),
        .perr_in    (perr_in),
        .ready      (bus.dout_ready),
        .dout       (bus.dout),
        .dout_valid (bus.dout_valid),
        .overflow   (bus.overflow),
        .parity_err (bus.parity_err)
    );
endmodule

// File: tb/tb_s_to_p.sv
// tb_s_to_p: LSB-first and MSB-first instances fed the same serial stream, checked against a scoreboard.
module tb_s_to_p;
    logic clk, rst, din, din_valid, sof, ready;
    int cmp_cnt = 0, err_cnt = 0, ferr_cnt = 0, ovf_cnt = 0;
    typedef struct { logic [3:0] lsb; logic [3:0] msb; logic perr; } exp_t;
    typedef struct { logic [3:0] seq; int gap; logic [3:0] lsb; logic [3:0] msb; } vec_t;
    exp_t sb[$];
    vec_t tbl[6];
    s2p_if #(.WIDTH(4)) bus0();
    s2p_if #(.WIDTH(4)) bus1();
    assign bus0.din = din;
    assign bus0.din_valid = din_valid;
    assign bus0.sof = sof;
    assign bus0.dout_ready = ready;
    assign bus1.din = din;
    assign bus1.din_valid = din_valid;
    assign bus1.sof = sof;
    assign bus1.dout_ready = ready;
    s_to_p #(.WIDTH(4), .LSB_FIRST(1)) u_lsb (.clk(clk), .rst(rst), .bus(bus0));
    s_to_p #(.WIDTH(4), .LSB_FIRST(0)) u_msb (.clk(clk), .rst(rst), .bus(bus1));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!rst) begin
            if (bus0.frame_err) ferr_cnt++;
            if (bus0.overflow) ovf_cnt++;
            if (bus0.dout_valid && ready) begin
                if (sb.size() == 0) begin
                    cmp_cnt++;
                    err_cnt++;
                    $display("FAIL unexpected_word: got %0h expected none", bus0.dout);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("dout_lsb", 32'(bus0.dout), 32'(e.lsb));
                    check("dout_msb", 32'(bus1.dout), 32'(e.msb));
                    check("valid_msb", 32'(bus1.dout_valid), 32'd1);
                    check("parity_err", 32'(bus0.parity_err), 32'(e.perr));
                end
            end
        end
    end
    task automatic send_bit(input logic b, input logic s, input int gap);
        for (int g = 0; g < gap; g++) begin
            din_valid = 1'b0;
            sof = 1'b0;
            @(posedge clk); #1;
        end
        din = b;
        din_valid = 1'b1;
        sof = s;
        @(posedge clk); #1;
        din_valid = 1'b0;
        sof = 1'b0;
    endtask
    // bits go out seq[0] first; gap before bit i is i*gap idle cycles
    task automatic frame(input logic [3:0] seq, input int gap, input logic [3:0] lsb,
                         input logic [3:0] msb, input logic par, input logic perr, input bit expect_out);
        if (expect_out) sb.push_back('{lsb, msb, perr});
        for (int i = 0; i < 4; i++) send_bit(seq[i], i == 0, i * gap);
`ifdef S2P_PARITY_EN
        send_bit(par, 1'b0, gap);
`endif
    endtask
    initial begin
        int f0;
        tbl[0] = '{4'hB, 0, 4'hB, 4'hD};
        tbl[1] = '{4'h6, 1, 4'h6, 4'h6};
        tbl[2] = '{4'h9, 0, 4'h9, 4'h9};
        tbl[3] = '{4'h1, 2, 4'h1, 4'h8};
        tbl[4] = '{4'h5, 0, 4'h5, 4'hA};
        tbl[5] = '{4'h3, 0, 4'h3, 4'hC};
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; sof = 1'b0; ready = 1'b1;
        #12;
        check("rst_dout", 32'(bus0.dout), 32'd0);
        check("rst_valid", 32'(bus0.dout_valid), 32'd0);
        check("rst_ferr", 32'(bus0.frame_err), 32'd0);
        check("rst_ovf", 32'(bus0.overflow), 32'd0);
        check("rst_perr", 32'(bus0.parity_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        // bits 1,1,0,1: valid exactly one cycle, starting right after the last bit
        sb.push_back('{4'hB, 4'hD, 1'b0});
        send_bit(1'b1, 1'b1, 0);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b0, 1'b0, 0);
        check("t1_not_yet", 32'(bus0.dout_valid), 32'd0);
        send_bit(1'b1, 1'b0, 0);
`ifdef S2P_PARITY_EN
        check("t1_wait_par", 32'(bus0.dout_valid), 32'd0);
        send_bit(1'b1, 1'b0, 0);
`endif
        check("t1_valid", 32'(bus0.dout_valid), 32'd1);
        @(posedge clk); #1;
        check("t1_drop", 32'(bus0.dout_valid), 32'd0);
        // overflow: held B survives, 5 is dropped
        ready = 1'b0;
        frame(4'hB, 0, 4'hB, 4'hD, 1'b1, 1'b0, 1);
        frame(4'h5, 0, 4'h5, 4'hA, 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        check("t3_ovf", 32'(ovf_cnt), 32'd1);
        check("t3_hold_lsb", 32'(bus0.dout), 32'hB);
        check("t3_hold_msb", 32'(bus1.dout), 32'hD);
        check("t3_hold_valid", 32'(bus0.dout_valid), 32'd1);
        ready = 1'b1;
        @(posedge clk); #1;
        check("t3_drained", 32'(bus0.dout_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t3_sb_empty", 32'(sb.size()), 32'd0);
        // sof mid-frame restarts
        f0 = ferr_cnt;
        send_bit(1'b1, 1'b1, 0);
        send_bit(1'b0, 1'b0, 0);
        frame(4'hE, 0, 4'hE, 4'h7, 1'b1, 1'b0, 1);
        @(posedge clk); #1;
        check("t4_ferr", 32'(ferr_cnt), 32'(f0 + 1));
        for (int i = 0; i < 6; i++)
            frame(tbl[i].seq, tbl[i].gap, tbl[i].lsb, tbl[i].msb, ^tbl[i].seq, 1'b0, 1);
        repeat (3) @(posedge clk);
        #1;
        // reset with a held word and a partial frame in flight
        ready = 1'b0;
        frame(4'hA, 0, 4'hA, 4'h5, 1'b0, 1'b0, 0);
        send_bit(1'b1, 1'b1, 0);
        send_bit(1'b0, 1'b0, 0);
        rst = 1'b1;
        #1;
        check("t5_rst_dout", 32'(bus0.dout), 32'd0);
        check("t5_rst_dout_msb", 32'(bus1.dout), 32'd0);
        check("t5_rst_valid", 32'(bus0.dout_valid), 32'd0);
        check("t5_rst_flags", 32'({bus0.frame_err, bus0.overflow, bus0.parity_err}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ready = 1'b1;
        frame(4'h3, 0, 4'h3, 4'hC, 1'b0, 1'b0, 1);
`ifdef S2P_PARITY_EN
        frame(4'hB, 0, 4'hB, 4'hD, 1'b1, 1'b0, 1);
        frame(4'hB, 0, 4'hB, 4'hD, 1'b0, 1'b1, 1);
`endif
        for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
        #1;
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        check("final_ferr", 32'(ferr_cnt), 32'd1);
        check("final_ovf", 32'(ovf_cnt), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
